// File: rtl/adder_amba_pkg.sv
// adder_amba_pkg: register offsets, CTRL bit positions and byte-strobe merge helper
package adder_amba_pkg;
    localparam logic [4:0] ADDR_R0   = 5'h00;
    localparam logic [4:0] ADDR_R1   = 5'h04;
    localparam logic [4:0] ADDR_R2   = 5'h08;
    localparam logic [4:0] ADDR_CTRL = 5'h0C;
    localparam logic [4:0] ADDR_LED  = 5'h10;
    localparam int CTRL_START = 0;
    localparam int CTRL_OP    = 1;
    localparam int CTRL_DONE  = 31;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/adder_amba_if.sv
// adder_amba_if: AXI4-Lite channel bundle with master/slave views
interface adder_amba_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/adder_amba_core.sv
// adder_amba_core: one-shot add/subtract with registered result and sticky done
module adder_amba_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    input  logic        start,
    input  logic        clr,
    output logic [31:0] result_q,
    output logic        done_q
);
    logic [31:0] result_d;
    logic        done_d;

    always_comb begin
        result_d = start ? (op ? a + b : a - b) : result_q;
        done_d   = start ? 1'b1 : (clr ? 1'b0 : done_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: rtl/adder_amba_top.sv
// adder_amba_top: AXI4-Lite register block around the add/subtract core, plus LED register
module adder_amba_top
    import adder_amba_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    adder_amba_if.slave s_axi,
    output logic        led0_b,
    output logic        led0_g,
    output logic        led0_r,
    output logic        led1_b
);
    logic awready_q, awready_d, wready_q, wready_d, aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
    logic bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic start_q, start_d, op_q, op_d;
    logic [2:0] awaddr_q, awaddr_d;
    logic [3:0] wstrb_q, wstrb_d, led_q, led_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, r0_q, r0_d, r1_q, r1_d;
    logic [31:0] result, rd_mux, ctrl_rd;
    logic done, aw_hs, w_hs, ar_hs, do_wr, ctrl_wr;
    logic unused_ok;

    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_AWADDR[1:0],
                         s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_ARADDR[1:0]};

    adder_amba_core u_core (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .a(r0_q), .b(r1_q), .op(op_q), .start(start_q),
        .clr(ctrl_wr), .result_q(result), .done_q(done)
    );

    always_comb begin
        aw_hs     = awready_q & s_axi.S_AXI_AWVALID;
        w_hs      = wready_q & s_axi.S_AXI_WVALID;
        ar_hs     = arready_q & s_axi.S_AXI_ARVALID;
        do_wr     = aw_lat_q & w_lat_q;
        ctrl_wr   = do_wr && awaddr_q == ADDR_CTRL[4:2];
        awready_d = s_axi.S_AXI_AWVALID & ~aw_lat_q & ~awready_q & ~bvalid_q;
        wready_d  = s_axi.S_AXI_WVALID & ~w_lat_q & ~wready_q & ~bvalid_q;
        aw_lat_d  = aw_hs | (aw_lat_q & ~do_wr);
        w_lat_d   = w_hs | (w_lat_q & ~do_wr);
        awaddr_d  = aw_hs ? s_axi.S_AXI_AWADDR[4:2] : awaddr_q;
        wdata_d   = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
        wstrb_d   = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
        bvalid_d  = do_wr | (bvalid_q & ~s_axi.S_AXI_BREADY);
        r0_d      = (do_wr && awaddr_q == ADDR_R0[4:2]) ? apply_strb(r0_q, wdata_q, wstrb_q) : r0_q;
        r1_d      = (do_wr && awaddr_q == ADDR_R1[4:2]) ? apply_strb(r1_q, wdata_q, wstrb_q) : r1_q;
        led_d     = (do_wr && awaddr_q == ADDR_LED[4:2] && wstrb_q[0]) ? wdata_q[3:0] : led_q;
        // START lives for exactly one cycle: the core consumes it on the following edge
        start_d   = (ctrl_wr & wstrb_q[0]) ? wdata_q[CTRL_START] : 1'b0;
        op_d      = (ctrl_wr & wstrb_q[0]) ? wdata_q[CTRL_OP] : op_q;
        arready_d = s_axi.S_AXI_ARVALID & ~arready_q & ~rvalid_q;
        rvalid_d  = ar_hs | (rvalid_q & ~s_axi.S_AXI_RREADY);
        rdata_d   = ar_hs ? rd_mux : rdata_q;
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_START] = start_q;
        ctrl_rd[CTRL_OP] = op_q;
        ctrl_rd[CTRL_DONE] = done;
        rd_mux = '0;
        case (s_axi.S_AXI_ARADDR[4:2])
            ADDR_R0[4:2]:   rd_mux = r0_q;
            ADDR_R1[4:2]:   rd_mux = r1_q;
            ADDR_R2[4:2]:   rd_mux = result;
            ADDR_CTRL[4:2]: rd_mux = ctrl_rd;
            ADDR_LED[4:2]:  rd_mux = {28'b0, led_q};
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            led_q     <= '0;
            start_q   <= 1'b0;
            op_q      <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_lat_q  <= aw_lat_d;
            w_lat_q   <= w_lat_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            led_q     <= led_d;
            start_q   <= start_d;
            op_q      <= op_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;
    assign {led1_b, led0_r, led0_g, led0_b} = led_q;
endmodule

// File: tb/tb_adder_amba_top.sv
// tb_adder_amba_top: directed AXI4-Lite transactions checked by read/write-response scoreboards
module tb_adder_amba_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led0_b, led0_g, led0_r, led1_b;
    int total = 0;
    int bad = 0;
    int nb = 0;
    logic [31:0] rq[$];
    string rn[$];
    logic [1:0] bq[$];
    string cur_name;

    always #5 clk = ~clk;

    adder_amba_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    adder_amba_top #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi.slave),
        .led0_b(led0_b), .led0_g(led0_g), .led0_r(led0_r), .led1_b(led1_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    always @(negedge clk) begin
        if (rst_n && axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
            if (rq.size() == 0) flag("rd_unexpected");
            else begin
                cur_name = rn.pop_front();
                chk(cur_name, axi.S_AXI_RDATA, rq.pop_front());
                chk({cur_name, "_rresp"}, {30'b0, axi.S_AXI_RRESP}, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
            nb++;
            if (bq.size() == 0) flag("wr_unexpected");
            else chk("bresp", {30'b0, axi.S_AXI_BRESP}, {30'b0, bq.pop_front()});
        end
    end

    task automatic wait_drain(input bit is_rd);
        int n = 0;
        while ((is_rd ? rq.size() : bq.size()) != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if ((is_rd ? rq.size() : bq.size()) != 0) begin
            flag(is_rd ? "rd_resp_timeout" : "wr_resp_timeout");
            rq.delete();
            rn.delete();
            bq.delete();
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok = 0;
        bit w_ok = 0;
        int n = 0;
        bq.push_back(2'b00);
        @(posedge clk); #1;
        axi.S_AXI_AWADDR = a; axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = s; axi.S_AXI_WVALID = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            @(negedge clk);
            if (axi.S_AXI_AWREADY) aw_ok = 1;
            if (axi.S_AXI_WREADY) w_ok = 1;
            @(posedge clk); #1;
            if (aw_ok) axi.S_AXI_AWVALID = 1'b0;
            if (w_ok) axi.S_AXI_WVALID = 1'b0;
            n++;
        end
        if (!(aw_ok && w_ok)) begin
            flag("wr_addr_data_timeout");
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID = 1'b0;
        end
        wait_drain(0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bit ok = 0;
        rq.push_back(exp);
        rn.push_back(name);
        @(posedge clk); #1;
        axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = axi.S_AXI_ARREADY;
        end
        if (!ok) flag({name, "_arready_timeout"});
        @(posedge clk); #1;
        axi.S_AXI_ARVALID = 1'b0;
        wait_drain(1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int nb0;
        bit seen;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 0; axi.S_AXI_BREADY = 1;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 0; axi.S_AXI_RREADY = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hs", {27'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
                         axi.S_AXI_ARREADY, axi.S_AXI_RVALID}, 32'h0);
        chk("reset_rdata", axi.S_AXI_RDATA, 32'h0);
        chk("reset_leds", {28'b0, led1_b, led0_r, led0_g, led0_b}, 32'h0);
        rst_n = 1'b1;

        axi_read(32'h0C, 32'h0, "ctrl_reset");
        axi_write(32'h00, 32'h2, 4'hF);
        axi_read(32'h00, 32'h2, "r0_rb");
        axi_write(32'h04, 32'h1, 4'hF);
        axi_read(32'h04, 32'h1, "r1_rb");

        axi_write(32'h0C, 32'h1, 4'hF);
        axi_read(32'h0C, 32'h8000_0000, "ctrl_done_sub");
        axi_read(32'h08, 32'h1, "r2_sub");
        axi_write(32'h0C, 32'h3, 4'hF);
        axi_read(32'h0C, 32'h8000_0002, "ctrl_done_add");
        axi_read(32'h08, 32'h3, "r2_add");
        axi_write(32'h00, 32'h0, 4'hF);
        axi_write(32'h0C, 32'h1, 4'hF);
        axi_read(32'h08, 32'hFFFF_FFFF, "r2_wrap");

        axi_write(32'h00, 32'h5, 4'hF);
        axi_read(32'h0C, 32'h8000_0000, "done_kept");
        axi_read(32'h08, 32'hFFFF_FFFF, "r2_kept");
        axi_write(32'h08, 32'hDEAD, 4'hF);
        axi_read(32'h08, 32'hFFFF_FFFF, "r2_ro");
        axi_write(32'h14, 32'h1234, 4'hF);
        axi_read(32'h14, 32'h0, "unmapped14");
        axi_read(32'h1C, 32'h0, "unmapped1c");
        axi_write(32'h0C, 32'h0, 4'hF);
        axi_read(32'h0C, 32'h0, "done_cleared");

        chk("leds_before", {28'b0, led1_b, led0_r, led0_g, led0_b}, 32'h0);
        axi_write(32'h10, 32'hF, 4'hF);
        axi_read(32'h10, 32'hF, "led_rb");
        chk("leds_after", {28'b0, led1_b, led0_r, led0_g, led0_b}, 32'hF);
        axi_write(32'h10, 32'hFFFF_FFF5, 4'hF);
        axi_read(32'h10, 32'h5, "led_upper");

        axi_write(32'h00, 32'hAABB_CCDD, 4'hF);
        axi_write(32'h00, 32'h1122_3344, 4'b0101);
        axi_read(32'h00, 32'hAA22_CC44, "wstrb_merge");

        // AW held past its handshake, W late, BREADY late
        axi.S_AXI_BREADY = 1'b0;
        nb0 = nb;
        bq.push_back(2'b00);
        @(posedge clk); #1;
        axi.S_AXI_AWADDR = 32'h04; axi.S_AXI_AWVALID = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = axi.S_AXI_AWREADY;
        end
        if (!seen) flag("slow_aw_timeout");
        @(posedge clk);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (axi.S_AXI_AWREADY) cnt++;
            @(posedge clk);
        end
        chk("aw_no_reaccept", cnt, 0);
        #1 axi.S_AXI_AWVALID = 1'b0;
        repeat (2) @(posedge clk);
        #1 axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = axi.S_AXI_WREADY;
        end
        if (!seen) flag("slow_w_timeout");
        @(posedge clk); #1 axi.S_AXI_WVALID = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = axi.S_AXI_BVALID;
        end
        if (!seen) flag("slow_bvalid_timeout");
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID) cnt++;
        end
        chk("bvalid_hold", cnt, 5);
        @(posedge clk); #1 axi.S_AXI_BREADY = 1'b1;
        wait_drain(0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID) cnt++;
        end
        chk("bvalid_drop", cnt, 0);
        chk("one_write", nb - nb0, 1);
        axi_read(32'h04, 32'h55, "slow_wr_data");

        // reset in the middle of a write
        @(posedge clk); #1;
        axi.S_AXI_AWADDR = 32'h00; axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA = 32'h77; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_hs", {27'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
                          axi.S_AXI_ARREADY, axi.S_AXI_RVALID}, 32'h0);
        chk("midrst_rdata", axi.S_AXI_RDATA, 32'h0);
        chk("midrst_leds", {28'b0, led1_b, led0_r, led0_g, led0_b}, 32'h0);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        axi_read(32'h00, 32'h0, "r0_after_rst");
        axi_read(32'h04, 32'h0, "r1_after_rst");
        axi_read(32'h10, 32'h0, "led_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
